// File: rtl/bp_mem_cmd_arbiter.sv
// Two-source round-robin arbiter onto the single bp_mem command port.
// A tag FIFO remembers the source of each issued command so in-order responses return to their requester.
module bp_mem_cmd_arbiter #(
    parameter int unsigned msg_width_p       = 32,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [2*msg_width_p-1:0]                   cmd_i,
    input  logic [1:0]                                 cmd_v_i,
    output logic [1:0]                                 cmd_ready_o,
    output logic [msg_width_p-1:0]                     mem_cmd_o,
    output logic                                       mem_cmd_v_o,
    input  logic                                       mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]                     mem_resp_i,
    input  logic                                       mem_resp_v_i,
    output logic                                       mem_resp_yumi_o,
    output logic [msg_width_p-1:0]                     resp_o,
    output logic [1:0]                                 resp_v_o,
    input  logic [1:0]                                 resp_yumi_i,
    output logic [$clog2(max_outstanding_p+1)-1:0]     outstanding_o,
    output logic                                       error_o
);

    localparam int unsigned DEPTH = max_outstanding_p;
    localparam int unsigned PTR_W = $clog2(max_outstanding_p);
    localparam int unsigned CNT_W = $clog2(max_outstanding_p + 1);

    logic [DEPTH-1:0] r_tags;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_rr_last;
    logic             r_hold;
    logic             r_hold_g;
    logic             r_error;

    logic             w_full;
    logic             w_empty;
    logic             w_can_issue;
    logic             w_rr_grant;
    logic             w_grant;
    logic [1:0]       w_grant_oh;
    logic             w_push;
    logic             w_pop;
    logic             w_head;
    logic             w_resp_v;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_can_issue = !w_full && mem_cmd_ready_i && reset_n_i;

    // A stalled offer keeps its grant so a late-arriving requester cannot steal the port.
    assign w_rr_grant  = (&cmd_v_i) ? ~r_rr_last : cmd_v_i[1];
    assign w_grant     = r_hold ? r_hold_g : w_rr_grant;
    assign w_grant_oh  = w_grant ? 2'b10 : 2'b01;

    assign mem_cmd_v_o = (|cmd_v_i) && !w_full && reset_n_i;
    assign mem_cmd_o   = w_grant ? cmd_i[msg_width_p +: msg_width_p] : cmd_i[0 +: msg_width_p];
    assign cmd_ready_o = cmd_v_i & w_grant_oh & {2{w_can_issue}};
    assign w_push      = |cmd_ready_o;

    // Response steering by the oldest outstanding tag.
    assign w_head          = r_tags[r_rd_ptr];
    assign w_resp_v        = mem_resp_v_i && !w_empty && reset_n_i;
    assign resp_o          = mem_resp_i;
    assign resp_v_o        = w_resp_v ? (w_head ? 2'b10 : 2'b01) : 2'b00;
    assign mem_resp_yumi_o = |(resp_yumi_i & resp_v_o);
    assign w_pop           = mem_resp_yumi_o;

    assign outstanding_o = r_count;
    assign error_o       = r_error;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_tags    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rr_last <= 1'b1;
            r_hold    <= 1'b0;
            r_hold_g  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_grant;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
                r_rr_last        <= w_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_hold   <= mem_cmd_v_o && !mem_cmd_ready_i;
            r_hold_g <= w_grant;
            if (mem_resp_v_i && w_empty) begin
                r_error <= 1'b1;
            end
        end
    end

    a_yumi_valid:   assert property (@(posedge clk_i) disable iff (!reset_n_i) mem_resp_yumi_o |-> mem_resp_v_i);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_n_i) w_push |-> !w_full);
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) w_pop |-> !w_empty);

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Bench for bp_mem_cmd_arbiter: vector table, hand sequences for reset/stall, and a
// scoreboarded memory model with a fixed response latency.
module tb_bp_mem_cmd_arbiter;

    localparam int unsigned MW  = 16;
    localparam int unsigned MO  = 4;
    localparam int unsigned CW  = $clog2(MO + 1);

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b0;
    logic [2*MW-1:0] cmd_i = '0;
    logic [1:0]      cmd_v_i = '0;
    logic [1:0]      cmd_ready_o;
    logic [MW-1:0]   mem_cmd_o;
    logic            mem_cmd_v_o;
    logic            mem_cmd_ready_i = 1'b0;
    logic [MW-1:0]   mem_resp_i = '0;
    logic            mem_resp_v_i = 1'b0;
    logic            mem_resp_yumi_o;
    logic [MW-1:0]   resp_o;
    logic [1:0]      resp_v_o;
    logic [1:0]      resp_yumi_i = '0;
    logic [CW-1:0]   outstanding_o;
    logic            error_o;

    bp_mem_cmd_arbiter #(.msg_width_p(MW), .max_outstanding_p(MO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
        .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
        .outstanding_o(outstanding_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] cmd_v; logic rdy; logic rv; logic [1:0] yumi;
        logic [1:0] e_cr; logic e_mcv; logic e_g; logic [1:0] e_rv; logic e_ym;
        logic [2:0] e_out; logic e_err;
    } vec_t;

    typedef struct { logic src; logic [MW-1:0] data; int t; } sb_t;

    vec_t vt[17];
    sb_t  sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive just after a posedge, return at the following negedge for sampling.
    task automatic drive(input logic rn, input logic [1:0] cv, input logic rdy, input logic rv,
                         input logic [1:0] ym, input logic [2*MW-1:0] ci, input logic [MW-1:0] ri);
        @(posedge clk_i);
        #1;
        reset_n_i       = rn;
        cmd_v_i         = cv;
        mem_cmd_ready_i = rdy;
        mem_resp_v_i    = rv;
        resp_yumi_i     = ym;
        cmd_i           = ci;
        mem_resp_i      = ri;
        @(negedge clk_i);
    endtask

    function automatic logic [1:0] oh(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] a_d, b_d, exp_d;
        logic          next_g;
        logic          resp_ok, active;
        int            sz, n_issued, n_resp;

        // cmd_v rdy rv yumi | cr mcv g rv ym out err
        vt[0]  = '{2'b11,1'b1,1'b0,2'b00, 2'b01,1'b1,1'b0,2'b00,1'b0,3'd0,1'b0};
        vt[1]  = '{2'b11,1'b1,1'b0,2'b00, 2'b10,1'b1,1'b1,2'b00,1'b0,3'd1,1'b0};
        vt[2]  = '{2'b01,1'b1,1'b0,2'b00, 2'b01,1'b1,1'b0,2'b00,1'b0,3'd2,1'b0};
        vt[3]  = '{2'b01,1'b1,1'b0,2'b00, 2'b01,1'b1,1'b0,2'b00,1'b0,3'd3,1'b0};
        vt[4]  = '{2'b11,1'b1,1'b0,2'b00, 2'b00,1'b0,1'b0,2'b00,1'b0,3'd4,1'b0};
        vt[5]  = '{2'b11,1'b1,1'b1,2'b01, 2'b00,1'b0,1'b0,2'b01,1'b1,3'd4,1'b0};
        vt[6]  = '{2'b11,1'b1,1'b0,2'b00, 2'b10,1'b1,1'b1,2'b00,1'b0,3'd3,1'b0};
        vt[7]  = '{2'b00,1'b0,1'b1,2'b01, 2'b00,1'b0,1'b0,2'b10,1'b0,3'd4,1'b0};
        vt[8]  = '{2'b00,1'b0,1'b1,2'b10, 2'b00,1'b0,1'b0,2'b10,1'b1,3'd4,1'b0};
        vt[9]  = '{2'b00,1'b0,1'b1,2'b01, 2'b00,1'b0,1'b0,2'b01,1'b1,3'd3,1'b0};
        vt[10] = '{2'b10,1'b1,1'b1,2'b01, 2'b10,1'b1,1'b1,2'b01,1'b1,3'd2,1'b0};
        vt[11] = '{2'b00,1'b0,1'b1,2'b11, 2'b00,1'b0,1'b0,2'b10,1'b1,3'd2,1'b0};
        vt[12] = '{2'b00,1'b0,1'b1,2'b10, 2'b00,1'b0,1'b0,2'b10,1'b1,3'd1,1'b0};
        vt[13] = '{2'b00,1'b0,1'b1,2'b00, 2'b00,1'b0,1'b0,2'b00,1'b0,3'd0,1'b0};
        vt[14] = '{2'b00,1'b0,1'b0,2'b00, 2'b00,1'b0,1'b0,2'b00,1'b0,3'd0,1'b1};
        vt[15] = '{2'b01,1'b0,1'b0,2'b00, 2'b00,1'b1,1'b0,2'b00,1'b0,3'd0,1'b1};
        vt[16] = '{2'b01,1'b1,1'b0,2'b00, 2'b01,1'b1,1'b0,2'b00,1'b0,3'd0,1'b1};

        // Reset with busy inputs: every handshake output must stay low.
        drive(1'b0, 2'b11, 1'b1, 1'b1, 2'b11, 32'h1234_5678, 16'h9999);
        drive(1'b0, 2'b11, 1'b1, 1'b1, 2'b11, 32'h1234_5678, 16'h9999);
        chk("rst_mcv",  32'(mem_cmd_v_o), 32'd0);
        chk("rst_cr",   32'(cmd_ready_o), 32'd0);
        chk("rst_rv",   32'(resp_v_o), 32'd0);
        chk("rst_ym",   32'(mem_resp_yumi_o), 32'd0);
        chk("rst_out",  32'(outstanding_o), 32'd0);
        chk("rst_err",  32'(error_o), 32'd0);

        for (int i = 0; i < 17; i++) begin
            a_d = 16'hA000 + 16'(i);
            b_d = 16'hB000 + 16'(i);
            drive(1'b1, vt[i].cmd_v, vt[i].rdy, vt[i].rv, vt[i].yumi, {b_d, a_d}, 16'hC000 + 16'(i));
            chk($sformatf("v%0d_cr", i),  32'(cmd_ready_o), 32'(vt[i].e_cr));
            chk($sformatf("v%0d_mcv", i), 32'(mem_cmd_v_o), 32'(vt[i].e_mcv));
            chk($sformatf("v%0d_rv", i),  32'(resp_v_o), 32'(vt[i].e_rv));
            chk($sformatf("v%0d_ym", i),  32'(mem_resp_yumi_o), 32'(vt[i].e_ym));
            chk($sformatf("v%0d_out", i), 32'(outstanding_o), 32'(vt[i].e_out));
            chk($sformatf("v%0d_err", i), 32'(error_o), 32'(vt[i].e_err));
            if (vt[i].e_mcv)
                chk($sformatf("v%0d_data", i), 32'(mem_cmd_o), 32'(vt[i].e_g ? b_d : a_d));
            if (vt[i].e_rv != 2'b00)
                chk($sformatf("v%0d_resp", i), 32'(resp_o), 32'(16'hC000 + 16'(i)));
        end

        // Reset mid-traffic (one outstanding, error set) clears everything.
        drive(1'b0, 2'b11, 1'b1, 1'b1, 2'b11, 32'hB111_A111, 16'h5555);
        chk("mid_rst_mcv", 32'(mem_cmd_v_o), 32'd0);
        chk("mid_rst_rv",  32'(resp_v_o), 32'd0);
        chk("mid_rst_ym",  32'(mem_resp_yumi_o), 32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0);
        chk("mid_rst_out", 32'(outstanding_o), 32'd0);
        chk("mid_rst_err", 32'(error_o), 32'd0);

        // First cycle out of reset: req 0 wins a tie.
        drive(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 32'hB222_A222, 16'h0);
        chk("first_cr",   32'(cmd_ready_o), 32'h1);
        chk("first_data", 32'(mem_cmd_o), 32'hA222);

        // Stall with req 1 granted; req 0 arriving mid-stall must not steal the grant.
        drive(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 32'hB333_A333, 16'h0);
        chk("st_pre_cr", 32'(cmd_ready_o), 32'h2);
        drive(1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 32'hB4B4_A4A4, 16'h0);
        chk("st0_mcv",  32'(mem_cmd_v_o), 32'd1);
        chk("st0_data", 32'(mem_cmd_o), 32'hB4B4);
        for (int k = 1; k < 3; k++) begin
            drive(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 32'hB4B4_A4A4, 16'h0);
            chk($sformatf("st%0d_cr", k),   32'(cmd_ready_o), 32'd0);
            chk($sformatf("st%0d_data", k), 32'(mem_cmd_o), 32'hB4B4);
        end
        drive(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 32'hB4B4_A4A4, 16'h0);
        chk("st_acc_cr",   32'(cmd_ready_o), 32'h2);
        chk("st_acc_data", 32'(mem_cmd_o), 32'hB4B4);
        drive(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 32'hB4B4_A4A4, 16'h0);
        chk("st_next_cr",   32'(cmd_ready_o), 32'h1);
        chk("st_next_data", 32'(mem_cmd_o), 32'hA4A4);
        chk("st_next_out",  32'(outstanding_o), 32'd3);
        drive(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 32'hB4B4_A4A4, 16'h0);
        chk("st_full_out", 32'(outstanding_o), 32'd4);
        chk("st_full_mcv", 32'(mem_cmd_v_o), 32'd0);

        drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0);

        // Continuous traffic against a memory answering 5 cycles after issue.
        next_g   = 1'b0;
        n_issued = 0;
        n_resp   = 0;
        for (int c = 0; c < 120; c++) begin
            active = (c < 40);
            if (!active && sb_q.size() == 0) break;
            resp_ok = (sb_q.size() > 0) && (sb_q[0].t + 5 <= c);
            a_d = 16'h1000 + 16'(c);
            b_d = 16'h2000 + 16'(c);
            drive(1'b1, active ? 2'b11 : 2'b00, 1'b1, resp_ok, 2'b11, {b_d, a_d},
                  resp_ok ? sb_q[0].data : 16'h0);
            sz = sb_q.size();
            chk("rr_out", 32'(outstanding_o), 32'(sz));
            chk("rr_mcv", 32'(mem_cmd_v_o), 32'(active && sz < 4));
            if (resp_ok) begin
                chk("rr_resp_v",    32'(resp_v_o), 32'(oh(sb_q[0].src)));
                chk("rr_resp_data", 32'(resp_o), 32'(sb_q[0].data));
                chk("rr_resp_ym",   32'(mem_resp_yumi_o), 32'd1);
                void'(sb_q.pop_front());
                n_resp++;
            end else begin
                chk("rr_resp_idle", 32'(resp_v_o), 32'd0);
            end
            if (active && sz < 4) begin
                exp_d = next_g ? b_d : a_d;
                chk("rr_grant", 32'(cmd_ready_o), 32'(oh(next_g)));
                chk("rr_data",  32'(mem_cmd_o), 32'(exp_d));
                sb_q.push_back('{next_g, exp_d, c});
                next_g = ~next_g;
                n_issued++;
            end else begin
                chk("rr_noacc", 32'(cmd_ready_o), 32'd0);
            end
        end
        chk("rr_drained",  32'(sb_q.size()), 32'd0);
        chk("rr_balance",  32'(n_resp), 32'(n_issued));
        chk("rr_progress", 32'(n_issued >= 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
